// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding a serialiser clocked by an
// internally generated 16x oversample tick. Bits go out LSB first, idle line high.
module uart_tx_fifo #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16,
    parameter int unsigned DVSR    = 163,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_en,
    input  logic [DBIT-1:0] wr_data,
    output logic            full,
    output logic            empty,
    output logic            tx,
    output logic            tx_busy
);

    localparam int unsigned DEPTH   = 2 ** FIFO_AW;
    localparam int unsigned CNTW    = FIFO_AW + 1;
    localparam int unsigned CW      = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int unsigned NW      = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int unsigned SW      = 5;
    localparam int unsigned OS_LAST = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DBIT-1:0]    mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CNTW-1:0]    count;
    logic [CNTW-1:0]    count_next;
    logic               push_c;
    logic               pop_c;

    // A push is judged only against the registered full flag, so a pop in
    // the same cycle never makes room for it.
    assign push_c = wr_en && !full;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        unique case ({push_c, pop_c})
            2'b10:   count_next = count + CNTW'(1);
            2'b01:   count_next = count - CNTW'(1);
            default: count_next = count;
        endcase
    end

    // Storage array; contents are meaningless once pointers are reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            count <= count_next;
            full  <= (count_next == CNTW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // ------------------------------------------------------------------
    // Oversample tick generator
    // ------------------------------------------------------------------
    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   tcnt;
    logic            tick_c;

    assign tick_c = (state != IDLE) && (tcnt == CW'(DVSR - 1));

    // Held at zero while idle so every frame starts on a fresh bit boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt <= '0;
        end else if ((state == IDLE) || tick_c) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    logic [SW-1:0]   s;
    logic [SW-1:0]   s_next;
    logic [NW-1:0]   n;
    logic [NW-1:0]   n_next;
    logic [DBIT-1:0] b;
    logic [DBIT-1:0] b_next;
    logic            tx_next_c;

    // Next-state, datapath and line-level decode.
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        pop_c      = 1'b0;
        tx_next_c  = 1'b1;
        unique case (state)
            IDLE: begin
                tx_next_c = 1'b1;
                if (!empty) begin
                    pop_c      = 1'b1;
                    b_next     = mem[rd_ptr];
                    s_next     = '0;
                    state_next = START;
                end
            end
            START: begin
                tx_next_c = 1'b0;
                if (tick_c) begin
                    if (s == SW'(OS_LAST)) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = DATA;
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
            DATA: begin
                tx_next_c = b[0];
                if (tick_c) begin
                    if (s == SW'(OS_LAST)) begin
                        s_next = '0;
                        b_next = b >> 1;
                        if (n == NW'(DBIT - 1)) begin
                            state_next = STOP;
                        end else begin
                            n_next = n + NW'(1);
                        end
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
            STOP: begin
                tx_next_c = 1'b1;
                if (tick_c) begin
                    if (s == SW'(SB_TICK - 1)) begin
                        s_next     = '0;
                        state_next = IDLE;
                    end else begin
                        s_next = s + SW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; tx lags the state by one clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            s       <= '0;
            n       <= '0;
            b       <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            state   <= state_next;
            s       <= s_next;
            n       <= n_next;
            b       <= b_next;
            tx      <= tx_next_c;
            tx_busy <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-level model predicts accepted bytes, pop times
// and flags; a line monitor decodes tx frames and checks them against a scoreboard.
module tb_uart_tx_fifo;

    localparam int unsigned DBIT      = 8;
    localparam int unsigned SB_TICK   = 16;
    localparam int unsigned DVSR      = 4;
    localparam int unsigned FIFO_AW   = 2;
    localparam int          DEPTH     = 2 ** FIFO_AW;
    localparam int          BIT_CLK   = 16 * DVSR;
    // start + data bits + stop, plus the single idle clock between frames
    localparam int          FRAME_CLK = (DBIT + 1) * BIT_CLK + SB_TICK * DVSR + 1;

    typedef struct {
        logic [7:0] data;
        int         start;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic       tx;
    logic       tx_busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    uart_tx_fifo #(
        .DBIT   (DBIT),
        .SB_TICK(SB_TICK),
        .DVSR   (DVSR),
        .FIFO_AW(FIFO_AW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .full   (full),
        .empty  (empty),
        .tx     (tx),
        .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference model: FIFO as a queue; the transmitter may take a new byte
    // once a full frame time has passed since the previous pop.
    logic [7:0] q_m[$];
    exp_t       exp_q[$];
    int         cyc     = 0;
    int         next_ok = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_m.delete();
            exp_q.delete();
            next_ok = 0;
        end else begin
            int   pre;
            bit   do_pop;
            exp_t e;
            cyc++;
            pre    = q_m.size();
            do_pop = (cyc >= next_ok) && (pre > 0);
            if (wr_en && pre < DEPTH) q_m.push_back(wr_data);
            if (do_pop) begin
                e.data  = q_m.pop_front();
                e.start = cyc + 1;
                exp_q.push_back(e);
                next_ok = cyc + FRAME_CLK;
            end
        end
    end

    // Line monitor: decodes frames mid-bit and checks flags every cycle.
    logic       in_frame = 1'b0;
    bit         unexp    = 1'b0;
    int         ph       = 0;
    logic [7:0] rx_byte;
    exp_t       cur;

    always @(negedge clk) begin
        if (!reset_n) begin
            in_frame = 1'b0;
            check("tx_in_reset", 32'(tx), 32'd1);
        end else if (in_frame) begin
            ph++;
            if (ph % BIT_CLK == BIT_CLK / 2) begin
                int i;
                i = ph / BIT_CLK;
                if (i == 0) begin
                    check("start_bit", 32'(tx), 32'd0);
                end else if (i <= int'(DBIT)) begin
                    rx_byte[i-1] = tx;
                end else begin
                    check("stop_bit", 32'(tx), 32'd1);
                    if (!unexp) check("frame_data", 32'(rx_byte), 32'(cur.data));
                    in_frame = 1'b0;
                end
            end
        end else if (tx == 1'b0) begin
            in_frame = 1'b1;
            ph       = 0;
            if (exp_q.size() == 0) begin
                unexp = 1'b1;
                chk_cnt++;
                $display("FAIL unexpected_frame: start seen at cycle %0d, none expected", cyc);
            end else begin
                unexp = 1'b0;
                cur   = exp_q.pop_front();
                check("frame_start_cycle", 32'(cyc), 32'(cur.start));
            end
        end
        check("empty_flag", 32'(empty), 32'(q_m.size() == 0));
        check("full_flag", 32'(full), 32'(q_m.size() == DEPTH));
        check("busy_flag", 32'(tx_busy), 32'(cyc < next_ok - 1));
    end

    task automatic push_seq(input logic [7:0] d[$]);
        foreach (d[i]) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = d[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (q_m.size() == 0 && cyc >= next_ok && !in_frame) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            chk_cnt++;
            $display("FAIL wait_idle: timeout, queue=%0d in_frame=%0d", q_m.size(), in_frame);
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [7:0] seq[$];
        bit         hit;

        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        repeat (5) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        reset_n = 1'b1;
        repeat (1000) @(negedge clk);
        check("idle_tx", 32'(tx), 32'd1);

        // single byte
        seq = '{8'hA5};
        push_seq(seq);
        wait_idle();
        check("busy_after_frame", 32'(tx_busy), 32'd0);

        // back-to-back burst
        seq = '{8'h00, 8'hFF, 8'h55};
        push_seq(seq);
        wait_idle();

        // overflow: six pushes into a four-deep FIFO
        seq = {};
        for (int i = 0; i < 6; i++) seq.push_back(8'($urandom));
        push_seq(seq);
        check("full_after_burst", 32'(full), 32'd1);
        wait_idle();

        // reset in the middle of data bit 3
        seq = '{8'h0F, 8'h33, 8'h44};
        push_seq(seq);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (in_frame && ph >= 4 * BIT_CLK + BIT_CLK / 2) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            chk_cnt++;
            $display("FAIL reset_midframe: data bit 3 never reached");
        end
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_tx", 32'(tx), 32'd1);
        check("async_rst_empty", 32'(empty), 32'd1);
        check("async_rst_busy", 32'(tx_busy), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2000) @(negedge clk);
        check("after_rst_empty", 32'(empty), 32'd1);

        // push on the pop cycle while full
        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66};
        push_seq(seq);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (cyc == next_ok - 1) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            chk_cnt++;
            $display("FAIL pop_push: pop cycle never reached");
        end
        check("full_before_pop", 32'(full), 32'd1);
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        check("full_after_pop", 32'(full), 32'd0);
        wait_idle();

        // random traffic
        for (int i = 0; i < 15000; i++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 149) == 0);
            wr_data = 8'($urandom);
        end
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("final_tx", 32'(tx), 32'd1);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
